// File: rtl/invader_fleet_ctrl_pkg.sv
// Shared constants for the invader fleet controller: geometry defaults,
// state encoding and the per-tick action classification.
package invader_fleet_ctrl_pkg;

  localparam int DEF_X_W       = 10;
  localparam int DEF_Y_W       = 10;
  localparam int DEF_COL_W     = 3;
  localparam int DEF_START_X   = 64;
  localparam int DEF_START_Y   = 64;
  localparam int DEF_STEP_X    = 8;
  localparam int DEF_DROP_Y    = 16;
  localparam int DEF_COL_PITCH = 48;
  localparam int DEF_INV_W     = 32;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_MARGIN    = 16;
  localparam int DEF_LAND_Y    = 416;
  localparam int DEF_TICK_CNT_W = 20;

  // Legacy-compatible state encoding shared with the rest of the game logic.
  localparam logic [1:0] ST_MARCH  = 2'd0;
  localparam logic [1:0] ST_HALT   = 2'd1;
  localparam logic [1:0] ST_LANDED = 2'd2;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_STEP,
    ACT_DROP,
    ACT_HALT
  } action_t;

endpackage

// File: rtl/invader_fleet_ctrl_if.sv
// Bundle between the game controller / sprite renderer and the fleet controller.
interface invader_fleet_ctrl_if #(
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int COL_W = 3
);
  logic             enb;
  logic             global_tick;
  logic             new_wave;
  logic [COL_W-1:0] col_min;
  logic [COL_W-1:0] col_max;
  logic             fleet_empty;
  logic [X_W-1:0]   fleet_x;
  logic [Y_W-1:0]   fleet_y;
  logic             dir_right;
  logic             anim_frame;
  logic             move_pulse;
  logic             landed;

  modport master (
    output enb, global_tick, new_wave, col_min, col_max, fleet_empty,
    input  fleet_x, fleet_y, dir_right, anim_frame, move_pulse, landed
  );

  modport slave (
    input  enb, global_tick, new_wave, col_min, col_max, fleet_empty,
    output fleet_x, fleet_y, dir_right, anim_frame, move_pulse, landed
  );
endinterface

// File: rtl/invader_fleet_ctrl_edge_calc.sv
// Combinational edge test: decides whether the fleet may take another march
// step in its current direction, and whether a drop would land it.
module fleet_edge_calc
  import invader_fleet_ctrl_pkg::*;
#(
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int STEP_X    = DEF_STEP_X,
  parameter int DROP_Y    = DEF_DROP_Y,
  parameter int COL_PITCH = DEF_COL_PITCH,
  parameter int INV_W     = DEF_INV_W,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int MARGIN    = DEF_MARGIN,
  parameter int LAND_Y    = DEF_LAND_Y
) (
  input  logic [X_W-1:0]   fleet_x,
  input  logic [Y_W-1:0]   fleet_y,
  input  logic [COL_W-1:0] col_min,
  input  logic [COL_W-1:0] col_max,
  input  logic             dir_right,
  output logic             can_step,
  output logic             will_land
);

  // Two extra bits keep every sum below from wrapping.
  localparam int E_W  = X_W + 2;
  localparam int YE_W = Y_W + 1;

  localparam logic [E_W-1:0]  PITCH       = E_W'(COL_PITCH);
  localparam logic [E_W-1:0]  SPRITE_W    = E_W'(INV_W);
  localparam logic [E_W-1:0]  STEP        = E_W'(STEP_X);
  localparam logic [E_W-1:0]  RIGHT_LIMIT = E_W'(SCREEN_W - MARGIN);
  localparam logic [E_W-1:0]  LEFT_LIMIT  = E_W'(MARGIN + STEP_X);
  localparam logic [YE_W-1:0] DROP        = YE_W'(DROP_Y);
  localparam logic [YE_W-1:0] LAND        = YE_W'(LAND_Y);

  logic [E_W-1:0]  left_edge;
  logic [E_W-1:0]  right_edge;
  logic [E_W-1:0]  min_offset;
  logic [E_W-1:0]  max_offset;
  logic [YE_W-1:0] dropped_y;

  always_comb begin
    min_offset = E_W'(col_min) * PITCH;
    max_offset = E_W'(col_max) * PITCH;
    left_edge  = {2'b00, fleet_x} + min_offset;
    right_edge = {2'b00, fleet_x} + max_offset + SPRITE_W;
    if (dir_right) begin
      can_step = (right_edge + STEP) <= RIGHT_LIMIT;
    end else begin
      can_step = left_edge >= LEFT_LIMIT;
    end
    dropped_y = {1'b0, fleet_y} + DROP;
    will_land = dropped_y >= LAND;
  end

endmodule

// File: rtl/invader_fleet_ctrl.sv
// Invader formation controller: one march step or edge drop per global_tick,
// publishing the registered anchor position, direction and animation phase.
module invader_fleet_ctrl
  import invader_fleet_ctrl_pkg::*;
#(
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int START_X   = DEF_START_X,
  parameter int START_Y   = DEF_START_Y,
  parameter int STEP_X    = DEF_STEP_X,
  parameter int DROP_Y    = DEF_DROP_Y,
  parameter int COL_PITCH = DEF_COL_PITCH,
  parameter int INV_W     = DEF_INV_W,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int MARGIN    = DEF_MARGIN,
  parameter int LAND_Y    = DEF_LAND_Y,
  parameter int COL_W     = DEF_COL_W
) (
  input logic                 clk,
  input logic                 rst,
  invader_fleet_ctrl_if.slave bus
);

  localparam logic [X_W-1:0] X0   = X_W'(START_X);
  localparam logic [Y_W-1:0] Y0   = Y_W'(START_Y);
  localparam logic [X_W-1:0] STEP = X_W'(STEP_X);
  localparam logic [Y_W-1:0] DROP = Y_W'(DROP_Y);

  logic [1:0]     state;
  logic [X_W-1:0] fleet_x;
  logic [Y_W-1:0] fleet_y;
  logic           dir_right;
  logic           anim_frame;
  logic           move_pulse;
  logic           landed;
  logic           can_step;
  logic           will_land;
  action_t        action;

  fleet_edge_calc #(
    .X_W       (X_W),
    .Y_W       (Y_W),
    .COL_W     (COL_W),
    .STEP_X    (STEP_X),
    .DROP_Y    (DROP_Y),
    .COL_PITCH (COL_PITCH),
    .INV_W     (INV_W),
    .SCREEN_W  (SCREEN_W),
    .MARGIN    (MARGIN),
    .LAND_Y    (LAND_Y)
  ) u_edge (
    .fleet_x   (fleet_x),
    .fleet_y   (fleet_y),
    .col_min   (bus.col_min),
    .col_max   (bus.col_max),
    .dir_right (dir_right),
    .can_step  (can_step),
    .will_land (will_land)
  );

  // Only a live, enabled tick in MARCH produces an action; emptiness wins over movement.
  always_comb begin
    action = ACT_NONE;
    if (state == ST_MARCH && bus.global_tick && bus.enb) begin
      if (bus.fleet_empty) begin
        action = ACT_HALT;
      end else if (can_step) begin
        action = ACT_STEP;
      end else begin
        action = ACT_DROP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_MARCH;
      fleet_x    <= X0;
      fleet_y    <= Y0;
      dir_right  <= 1'b1;
      anim_frame <= 1'b0;
      move_pulse <= 1'b0;
      landed     <= 1'b0;
    end else if (bus.new_wave) begin
      state      <= ST_MARCH;
      fleet_x    <= X0;
      fleet_y    <= Y0;
      dir_right  <= 1'b1;
      move_pulse <= 1'b0;
      landed     <= 1'b0;
    end else begin
      move_pulse <= 1'b0;
      case (action)
        ACT_HALT: begin
          state <= ST_HALT;
        end
        ACT_STEP: begin
          fleet_x    <= dir_right ? fleet_x + STEP : fleet_x - STEP;
          move_pulse <= 1'b1;
          anim_frame <= ~anim_frame;
        end
        ACT_DROP: begin
          fleet_y    <= fleet_y + DROP;
          dir_right  <= ~dir_right;
          move_pulse <= 1'b1;
          anim_frame <= ~anim_frame;
          if (will_land) begin
            landed <= 1'b1;
            state  <= ST_LANDED;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.fleet_x    = fleet_x;
  assign bus.fleet_y    = fleet_y;
  assign bus.dir_right  = dir_right;
  assign bus.anim_frame = anim_frame;
  assign bus.move_pulse = move_pulse;
  assign bus.landed     = landed;

endmodule

// File: tb/tb_invader_fleet_ctrl.sv
// Directed bench for invader_fleet_ctrl: edges, live-column dependence,
// landing, and tick gating / collision priority.
module tb_invader_fleet_ctrl;
  import invader_fleet_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  invader_fleet_ctrl_if #(.X_W(10), .Y_W(10), .COL_W(3)) bus ();

  invader_fleet_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are inspected on the next falling edge.
  task automatic do_tick();
    @(negedge clk);
    bus.global_tick = 1'b1;
    @(negedge clk);
    bus.global_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.fleet_x !== 10'd64) begin miscompares++; $display("[TB] FAIL reset_x: got %0d expected 64", bus.fleet_x); end
    vectors++; if (bus.fleet_y !== 10'd64) begin miscompares++; $display("[TB] FAIL reset_y: got %0d expected 64", bus.fleet_y); end
    vectors++; if (bus.dir_right !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dir: got %b expected 1", bus.dir_right); end
    vectors++; if (bus.landed !== 1'b0 || bus.move_pulse !== 1'b0 || bus.anim_frame !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_flags: landed/pulse/anim got %b%b%b expected 000", bus.landed, bus.move_pulse, bus.anim_frame);
    end
    bus.col_min = 3'd0;
    bus.col_max = 3'd7;
    do_tick();
    vectors++; if (bus.fleet_x !== 10'd72) begin miscompares++; $display("[TB] FAIL first_tick_x: got %0d expected 72", bus.fleet_x); end
    vectors++; if (bus.move_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL first_tick_pulse: got %b expected 1", bus.move_pulse); end
    vectors++; if (bus.anim_frame !== 1'b1) begin miscompares++; $display("[TB] FAIL first_tick_anim: got %b expected 1", bus.anim_frame); end
    @(negedge clk);
    vectors++; if (bus.move_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL pulse_width: got %b expected 0", bus.move_pulse); end
  endtask

  task automatic test_right_edge();
    do_reset();
    for (int i = 0; i < 24; i++) do_tick();
    vectors++; if (bus.fleet_x !== 10'd256 || bus.fleet_y !== 10'd64) begin
      miscompares++; $display("[TB] FAIL right_march: x,y got %0d,%0d expected 256,64", bus.fleet_x, bus.fleet_y);
    end
    do_tick();
    vectors++; if (bus.fleet_y !== 10'd80 || bus.dir_right !== 1'b0 || bus.fleet_x !== 10'd256) begin
      miscompares++; $display("[TB] FAIL right_drop: x,y,dir got %0d,%0d,%b expected 256,80,0", bus.fleet_x, bus.fleet_y, bus.dir_right);
    end
    vectors++; if (bus.move_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL right_drop_pulse: got %b expected 1", bus.move_pulse); end
  endtask

  task automatic test_left_edge();
    for (int i = 0; i < 30; i++) do_tick();
    vectors++; if (bus.fleet_x !== 10'd16 || bus.fleet_y !== 10'd80) begin
      miscompares++; $display("[TB] FAIL left_march: x,y got %0d,%0d expected 16,80", bus.fleet_x, bus.fleet_y);
    end
    do_tick();
    vectors++; if (bus.fleet_y !== 10'd96 || bus.dir_right !== 1'b1 || bus.fleet_x !== 10'd16) begin
      miscompares++; $display("[TB] FAIL left_drop: x,y,dir got %0d,%0d,%b expected 16,96,1", bus.fleet_x, bus.fleet_y, bus.dir_right);
    end
  endtask

  // With columns 2..5 alive the right reversal moves out by 96 (256 -> 352) and
  // the left side keeps stepping past x=16, where the full fleet would drop.
  task automatic test_live_columns();
    bus.col_min = 3'd2;
    bus.col_max = 3'd5;
    for (int i = 0; i < 42; i++) do_tick();
    vectors++; if (bus.fleet_x !== 10'd352 || bus.fleet_y !== 10'd96 || bus.dir_right !== 1'b1) begin
      miscompares++; $display("[TB] FAIL cols_right_march: x,y,dir got %0d,%0d,%b expected 352,96,1", bus.fleet_x, bus.fleet_y, bus.dir_right);
    end
    do_tick();
    vectors++; if (bus.fleet_x !== 10'd352 || bus.fleet_y !== 10'd112 || bus.dir_right !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cols_right_drop: x,y,dir got %0d,%0d,%b expected 352,112,0", bus.fleet_x, bus.fleet_y, bus.dir_right);
    end
    for (int i = 0; i < 43; i++) do_tick();
    vectors++; if (bus.fleet_x !== 10'd8 || bus.fleet_y !== 10'd112 || bus.dir_right !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cols_left_shift: x,y,dir got %0d,%0d,%b expected 8,112,0", bus.fleet_x, bus.fleet_y, bus.dir_right);
    end
    bus.col_min = 3'd0;
    bus.col_max = 3'd7;
    do_tick();
    vectors++; if (bus.fleet_x !== 10'd8 || bus.fleet_y !== 10'd128 || bus.dir_right !== 1'b1) begin
      miscompares++; $display("[TB] FAIL cols_left_drop: x,y,dir got %0d,%0d,%b expected 8,128,1", bus.fleet_x, bus.fleet_y, bus.dir_right);
    end
  endtask

  // First drop at tick 25, then one every 31 ticks: drop 22 lands at tick 676.
  task automatic test_landing();
    int ticks;
    int drops;
    logic [9:0] prev_y;
    ticks = 0;
    drops = 0;
    do_reset();
    while (bus.landed !== 1'b1 && ticks < 2000) begin
      prev_y = bus.fleet_y;
      do_tick();
      ticks++;
      if (bus.fleet_y !== prev_y) drops++;
    end
    vectors++; if (ticks !== 676) begin miscompares++; $display("[TB] FAIL land_ticks: got %0d expected 676", ticks); end
    vectors++; if (drops !== 22) begin miscompares++; $display("[TB] FAIL land_drops: got %0d expected 22", drops); end
    vectors++; if (bus.fleet_y !== 10'd416 || bus.fleet_x !== 10'd16 || bus.landed !== 1'b1) begin
      miscompares++; $display("[TB] FAIL land_pos: x,y,landed got %0d,%0d,%b expected 16,416,1", bus.fleet_x, bus.fleet_y, bus.landed);
    end
    vectors++; if (bus.dir_right !== 1'b1 || bus.anim_frame !== 1'b0) begin
      miscompares++; $display("[TB] FAIL land_dir_anim: got %b%b expected 10", bus.dir_right, bus.anim_frame);
    end
    for (int i = 0; i < 3; i++) do_tick();
    vectors++; if (bus.fleet_y !== 10'd416 || bus.fleet_x !== 10'd16 || bus.move_pulse !== 1'b0 || bus.landed !== 1'b1) begin
      miscompares++; $display("[TB] FAIL landed_frozen: x,y,pulse,landed got %0d,%0d,%b,%b expected 16,416,0,1",
                              bus.fleet_x, bus.fleet_y, bus.move_pulse, bus.landed);
    end
    @(negedge clk);
    bus.new_wave = 1'b1;
    @(negedge clk);
    bus.new_wave = 1'b0;
    vectors++; if (bus.fleet_x !== 10'd64 || bus.fleet_y !== 10'd64 || bus.landed !== 1'b0 || bus.dir_right !== 1'b1) begin
      miscompares++; $display("[TB] FAIL new_wave_restore: x,y,landed,dir got %0d,%0d,%b,%b expected 64,64,0,1",
                              bus.fleet_x, bus.fleet_y, bus.landed, bus.dir_right);
    end
  endtask

  task automatic test_gating();
    bus.enb = 1'b0;
    do_tick();
    bus.enb = 1'b1;
    vectors++; if (bus.fleet_x !== 10'd64 || bus.move_pulse !== 1'b0) begin
      miscompares++; $display("[TB] FAIL enb_low: x,pulse got %0d,%b expected 64,0", bus.fleet_x, bus.move_pulse);
    end
    do_tick();
    vectors++; if (bus.fleet_x !== 10'd72 || bus.anim_frame !== 1'b1) begin
      miscompares++; $display("[TB] FAIL enb_high: x,anim got %0d,%b expected 72,1", bus.fleet_x, bus.anim_frame);
    end
    @(negedge clk);
    bus.new_wave = 1'b1;
    bus.global_tick = 1'b1;
    @(negedge clk);
    bus.new_wave = 1'b0;
    bus.global_tick = 1'b0;
    vectors++; if (bus.fleet_x !== 10'd64 || bus.move_pulse !== 1'b0 || bus.anim_frame !== 1'b1) begin
      miscompares++; $display("[TB] FAIL wave_vs_tick: x,pulse,anim got %0d,%b,%b expected 64,0,1", bus.fleet_x, bus.move_pulse, bus.anim_frame);
    end
    bus.fleet_empty = 1'b1;
    do_tick();
    bus.fleet_empty = 1'b0;
    vectors++; if (bus.fleet_x !== 10'd64 || bus.move_pulse !== 1'b0 || bus.anim_frame !== 1'b1) begin
      miscompares++; $display("[TB] FAIL empty_tick: x,pulse,anim got %0d,%b,%b expected 64,0,1", bus.fleet_x, bus.move_pulse, bus.anim_frame);
    end
    do_tick();
    vectors++; if (bus.fleet_x !== 10'd64 || bus.move_pulse !== 1'b0) begin
      miscompares++; $display("[TB] FAIL halt_holds: x,pulse got %0d,%b expected 64,0", bus.fleet_x, bus.move_pulse);
    end
    @(negedge clk);
    bus.new_wave = 1'b1;
    @(negedge clk);
    bus.new_wave = 1'b0;
    do_tick();
    vectors++; if (bus.fleet_x !== 10'd72 || bus.anim_frame !== 1'b0 || bus.move_pulse !== 1'b1) begin
      miscompares++; $display("[TB] FAIL halt_exit: x,anim,pulse got %0d,%b,%b expected 72,0,1", bus.fleet_x, bus.anim_frame, bus.move_pulse);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.global_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.global_tick = 1'b0;
    vectors++; if (bus.fleet_x !== 10'd64 || bus.fleet_y !== 10'd64 || bus.anim_frame !== 1'b0 || bus.move_pulse !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_vs_tick: x,y,anim,pulse got %0d,%0d,%b,%b expected 64,64,0,0",
                              bus.fleet_x, bus.fleet_y, bus.anim_frame, bus.move_pulse);
    end
  endtask

  initial begin
    bus.enb         = 1'b1;
    bus.global_tick = 1'b0;
    bus.new_wave    = 1'b0;
    bus.col_min     = 3'd0;
    bus.col_max     = 3'd7;
    bus.fleet_empty = 1'b0;
    test_reset();
    test_right_edge();
    test_left_edge();
    test_live_columns();
    test_landing();
    test_gating();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
